// File: rtl/sys_commit_pkg.sv
// Shared types and constants for the system-unit commit stage.
// Build option: SYS_COMMIT_MTVAL_EN adds the mtval trap-entry write state.
package sys_commit_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned SYS_CSR_AW  = 12;
    localparam int unsigned SYS_CAUSE_W = 16;

    localparam logic [SYS_CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [SYS_CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [SYS_CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [SYS_CSR_AW-1:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef struct packed {
        logic [SYS_CSR_AW-1:0]  csr_addr;
        logic [XLEN-1:0]        this_pc;
        logic [XLEN-1:0]        csr_wdata;
        logic                   csr_update;
        logic                   trap;
        logic [SYS_CAUSE_W-1:0] trap_cause;
        logic [XLEN-1:0]        new_pc;
        logic                   use_new_pc;
    } syswb_tdata_t;

    typedef enum logic [2:0] {
        IDLE,
        CSR_WR,
        TRAP_EPC,
        TRAP_CAUSE,
`ifdef SYS_COMMIT_MTVAL_EN
        TRAP_TVAL,
`endif
        TRAP_STATUS,
        REDIRECT
    } sys_commit_state_e;

endpackage

// File: rtl/sys_commit_if.sv
// AXI-stream style handshake carrying system-unit results to write-back.
interface axis_if;
    import sys_commit_pkg::*;

    logic         tvalid;
    logic         tready;
    syswb_tdata_t tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);

endinterface

// File: rtl/sys_commit_cause.sv
// Maps a one-hot trap cause vector to the mcause exception code (lowest bit wins).
module cause_encoder
    import sys_commit_pkg::*;
#(
    parameter int unsigned CAUSE_W = SYS_CAUSE_W
) (
    input  logic [CAUSE_W-1:0] trap_cause,
    output logic [XLEN-1:0]    mcause
);

    logic found;

    // An all-zero vector yields code 0 with the interrupt bit clear.
    always_comb begin
        mcause = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < CAUSE_W; i++) begin
            if (!found && trap_cause[i]) begin
                mcause = XLEN'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_commit.sv
// Commits system-unit results: CSR write-back, trap entry and PC redirect.
// Build option: SYS_COMMIT_MTVAL_EN inserts an mtval=0 write after mcause.
module sys_commit
    import sys_commit_pkg::*;
#(
    parameter int unsigned CSR_AW  = SYS_CSR_AW,
    parameter int unsigned CAUSE_W = SYS_CAUSE_W
) (
    input  logic              clk,
    input  logic              rst,
    axis_if.s                 syswb_axis_if,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   mstatus_rdata,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              invalidate,
    output logic              retire
);

    sys_commit_state_e state;
    syswb_tdata_t      beat_q;
    syswb_tdata_t      beat_in;
    logic              tready_q;
    logic              handshake;
    logic [XLEN-1:0]   mcause_code;
    logic [XLEN-1:0]   mstatus_next;

    assign syswb_axis_if.tready = tready_q;
    assign beat_in              = syswb_axis_if.tdata;
    assign handshake            = syswb_axis_if.tvalid && tready_q;

    cause_encoder #(.CAUSE_W(CAUSE_W)) u_cause_encoder (
        .trap_cause (beat_q.trap_cause),
        .mcause     (mcause_code)
    );

    always_comb begin
        mstatus_next                                = mstatus_rdata;
        mstatus_next[MSTATUS_MPIE]                  = mstatus_rdata[MSTATUS_MIE];
        mstatus_next[MSTATUS_MIE]                   = 1'b0;
        mstatus_next[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Outputs are loaded on the edge that enters a state, so they are valid
    // for exactly the cycle spent in that state. tready stays low during the
    // cycle a retire pulse is shown in IDLE, so a beat is never overlapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            beat_q         <= '0;
            tready_q       <= 1'b0;
            csr_we         <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            invalidate     <= 1'b0;
            retire         <= 1'b0;
        end else begin
            tready_q       <= 1'b0;
            csr_we         <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            invalidate     <= 1'b0;
            retire         <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        beat_q <= beat_in;
                        if (beat_in.trap) begin
                            state     <= TRAP_EPC;
                            csr_we    <= 1'b1;
                            csr_waddr <= CSR_MEPC;
                            csr_wdata <= {beat_in.this_pc[XLEN-1:2], 2'b00};
                        end else if (beat_in.csr_update) begin
                            state     <= CSR_WR;
                            csr_we    <= 1'b1;
                            csr_waddr <= beat_in.csr_addr;
                            csr_wdata <= beat_in.csr_wdata;
                        end else if (beat_in.use_new_pc) begin
                            state          <= REDIRECT;
                            redirect_valid <= 1'b1;
                            invalidate     <= 1'b1;
                            redirect_pc    <= beat_in.new_pc;
                            retire         <= 1'b1;
                        end else begin
                            retire <= 1'b1;
                        end
                    end else begin
                        tready_q <= 1'b1;
                    end
                end
                CSR_WR: begin
                    retire <= 1'b1;
                    if (beat_q.use_new_pc) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        invalidate     <= 1'b1;
                        redirect_pc    <= beat_q.new_pc;
                    end else begin
                        state <= IDLE;
                    end
                end
                TRAP_EPC: begin
                    state     <= TRAP_CAUSE;
                    csr_we    <= 1'b1;
                    csr_waddr <= CSR_MCAUSE;
                    csr_wdata <= mcause_code;
                end
`ifdef SYS_COMMIT_MTVAL_EN
                TRAP_CAUSE: begin
                    state     <= TRAP_TVAL;
                    csr_we    <= 1'b1;
                    csr_waddr <= CSR_MTVAL;
                    csr_wdata <= '0;
                end
                TRAP_TVAL: begin
                    state     <= TRAP_STATUS;
                    csr_we    <= 1'b1;
                    csr_waddr <= CSR_MSTATUS;
                    csr_wdata <= mstatus_next;
                end
`else
                TRAP_CAUSE: begin
                    state     <= TRAP_STATUS;
                    csr_we    <= 1'b1;
                    csr_waddr <= CSR_MSTATUS;
                    csr_wdata <= mstatus_next;
                end
`endif
                TRAP_STATUS: begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                    invalidate     <= 1'b1;
                    redirect_pc    <= beat_q.new_pc;
                end
                REDIRECT: begin
                    state    <= IDLE;
                    tready_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
